// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with a flop-based register file,
// almost-full/almost-empty flags and registered per-request ack/err pulses.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous reset, active-high
//   wr_en, d_in  write request and write data
//   rd_en        read request
//   d_out        read data (registered, 1-cycle latency aligned with rd_ack)
//   full, empty, almost_full, almost_empty
//                decodes of the registered data_count
//   wr_ack/wr_err, rd_ack/rd_err
//                outcome of the previous cycle's request
//   data_count   words stored, 0..DEPTH
//
// Define FIFO_FWFT_EN for first-word fall-through. In that mode d_out shows
// the head word combinationally whenever the FIFO is not empty, and rd_en pops it.
module fifo_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   data_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
    logic                  rd_ok, wr_ok;

    assign full         = int'(count_q) == DEPTH;
    assign empty        = count_q == '0;
    assign almost_full  = int'(count_q) >= AFULL_THRESH;
    assign almost_empty = int'(count_q) <= AEMPTY_THRESH;
    assign data_count   = count_q;
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign rd_ack       = rd_ack_q;
    assign rd_err       = rd_err_q;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    always_comb begin
        head_d  = rd_ok ? head_q + PTR_ONE : head_q;
        tail_d  = wr_ok ? tail_q + PTR_ONE : tail_q;
        count_d = (wr_ok & ~rd_ok) ? count_q + CNT_ONE :
                  (rd_ok & ~wr_ok) ? count_q - CNT_ONE : count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wr_ack_q <= wr_ok;
            wr_err_q <= wr_en & ~wr_ok;
            rd_ack_q <= rd_ok;
            rd_err_q <= rd_en & ~rd_ok;
        end
    end

    // Storage is deliberately left unreset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[tail_q] <= d_in;
    end

`ifdef FIFO_FWFT_EN
    assign d_out = empty ? '0 : mem_q[head_q];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dout_q <= '0;
        else       dout_q <= rd_ok ? mem_q[head_q] : '0;
    end

    assign d_out = dout_q;
`endif
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: table-driven bench for fifo_param with a read-data scoreboard.
module tb_fifo_param;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] d_in = '0;
    logic [31:0] d_out;
    logic        full, empty, almost_full, almost_empty;
    logic        wr_ack, wr_err, rd_ack, rd_err;
    logic [3:0]  data_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] d;
        int          cnt;
        logic        wa;
        logic        we;
        logic        ra;
        logic        re;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];

    fifo_param dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
        .d_out(d_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_ack(rd_ack), .rd_err(rd_err), .data_count(data_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int cnt);
        chk({tag, " count"}, 32'(data_count), 32'(cnt));
        chk({tag, " full"}, 32'(full), 32'(cnt == 8));
        chk({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= 6));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 1));
    endtask

    task automatic add(input logic w, input logic r, input logic [31:0] d, input int cnt,
                       input logic wa, input logic we, input logic ra, input logic re);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.cnt = cnt;
        v.wa = wa; v.we = we; v.ra = ra; v.re = re;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [31:0] exp_do;
        @(negedge clk);
        wr_en = v.w;
        rd_en = v.r;
        d_in  = v.d;
        @(posedge clk);
        #1;
        if (v.wa) sb.push_back(v.d);
        exp_do = '0;
        if (v.ra) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s scoreboard: got empty queue expected a word", tag);
            end else exp_do = sb.pop_front();
        end
        chk_flags(tag, v.cnt);
        chk({tag, " wr_ack"}, 32'(wr_ack), 32'(v.wa));
        chk({tag, " wr_err"}, 32'(wr_err), 32'(v.we));
        chk({tag, " rd_ack"}, 32'(rd_ack), 32'(v.ra));
        chk({tag, " rd_err"}, 32'(rd_err), 32'(v.re));
        chk({tag, " d_out"}, d_out, exp_do);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_flags(tag, 0);
        chk({tag, " acks"}, 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'(0));
        chk({tag, " d_out"}, d_out, 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) add(1, 0, 32'hA0 + 32'(i), i + 1, 1, 0, 0, 0);
        add(1, 0, 32'hFF, 8, 0, 1, 0, 0);
        add(1, 1, 32'hB0, 8, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 32'h0, 7 - i, 0, 0, 1, 0);
        add(0, 1, 32'h0, 0, 0, 0, 0, 1);
        add(0, 0, 32'h0, 0, 0, 0, 0, 0);
        add(1, 1, 32'h55, 1, 1, 0, 0, 1);
        add(0, 1, 32'h0, 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v.w = 1; v.r = 0; v.d = 32'hC0 + 32'(i); v.cnt = i + 1;
            v.wa = 1; v.we = 0; v.ra = 0; v.re = 0;
            apply(v, $sformatf("fill%0d", i));
        end
        begin
            vec_t v;
            v.w = 0; v.r = 1; v.d = 0; v.cnt = 5;
            v.wa = 0; v.we = 0; v.ra = 1; v.re = 0;
            apply(v, "pre_reset_read");
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_reset_state("async_reset");
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        begin
            vec_t v;
            v.w = 0; v.r = 1; v.d = 0; v.cnt = 0;
            v.wa = 0; v.we = 0; v.ra = 0; v.re = 1;
            apply(v, "post_reset_read");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
